// File: rtl/vga_timing_engine.sv
// Parametrised VGA timing generator with a look-ahead pixel request
// and a delay-matched sync/blank/colour output stage.
module vga_timing_engine #(
  parameter int H_ACT      = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACT      = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int COLOR_W    = 8,
  parameter int FETCH_LEAD = 2,
  localparam int H_TOT     = H_ACT + H_FP + H_SYNC + H_BP,
  localparam int V_TOT     = V_ACT + V_FP + V_SYNC + V_BP,
  localparam int H_W       = $clog2(H_TOT),
  localparam int V_W       = $clog2(V_TOT)
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iEnable,
  input  logic [COLOR_W-1:0] iRed,
  input  logic [COLOR_W-1:0] iGreen,
  input  logic [COLOR_W-1:0] iBlue,
  output logic               oReq,
  output logic [H_W-1:0]     oReq_X,
  output logic [V_W-1:0]     oReq_Y,
  output logic               oFrame_Start,
  output logic               oLine_Start,
  output logic [COLOR_W-1:0] oVGA_R,
  output logic [COLOR_W-1:0] oVGA_G,
  output logic [COLOR_W-1:0] oVGA_B,
  output logic               oVGA_H_SYNC,
  output logic               oVGA_V_SYNC,
  output logic               oVGA_BLANK,
  output logic               oVGA_SYNC,
  output logic               oVGA_CLK
);

  localparam logic [H_W-1:0] H_LAST = H_W'(H_TOT - 1);
  localparam logic [H_W-1:0] H_VIS  = H_W'(H_ACT);
  localparam logic [H_W-1:0] HS_BEG = H_W'(H_ACT + H_FP);
  localparam logic [H_W-1:0] HS_END = H_W'(H_ACT + H_FP + H_SYNC - 1);
  localparam logic [V_W-1:0] V_LAST = V_W'(V_TOT - 1);
  localparam logic [V_W-1:0] V_VIS  = V_W'(V_ACT);
  localparam logic [V_W-1:0] VS_BEG = V_W'(V_ACT + V_FP);
  localparam logic [V_W-1:0] VS_END = V_W'(V_ACT + V_FP + V_SYNC - 1);

  logic [H_W-1:0]        hc_q, hc_d;
  logic [V_W-1:0]        vc_q, vc_d;
  logic [FETCH_LEAD-1:0] blk_q, blk_d;
  logic [FETCH_LEAD-1:0] hs_q, hs_d;
  logic [FETCH_LEAD-1:0] vs_q, vs_d;
  logic [COLOR_W-1:0]    r_q, r_d;
  logic [COLOR_W-1:0]    g_q, g_d;
  logic [COLOR_W-1:0]    b_q, b_d;
  logic                  run, req, hs_a, vs_a;

  assign run  = iEnable & iRST_N;
  assign req  = run && (hc_q < H_VIS) && (vc_q < V_VIS);
  assign hs_a = run && (hc_q >= HS_BEG) && (hc_q <= HS_END);
  assign vs_a = run && (vc_q >= VS_BEG) && (vc_q <= VS_END);

  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (!run) begin
      hc_d = '0;
      vc_d = '0;
    end else if (hc_q == H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
    end else begin
      hc_d = hc_q + 1'b1;
    end
  end

  // Each stage holds the active-level flags; stage 0 takes the current counters.
  always_comb begin
    blk_d = FETCH_LEAD'({blk_q, req});
    hs_d  = FETCH_LEAD'({hs_q, hs_a});
    vs_d  = FETCH_LEAD'({vs_q, vs_a});
    r_d   = iRed;
    g_d   = iGreen;
    b_d   = iBlue;
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      hc_q  <= '0;
      vc_q  <= '0;
      blk_q <= '0;
      hs_q  <= '0;
      vs_q  <= '0;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
    end else begin
      hc_q  <= hc_d;
      vc_q  <= vc_d;
      blk_q <= blk_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      r_q   <= r_d;
      g_q   <= g_d;
      b_q   <= b_d;
    end
  end

  assign oReq         = req;
  assign oReq_X       = hc_q;
  assign oReq_Y       = vc_q;
  assign oFrame_Start = run && (hc_q == '0) && (vc_q == '0);
  assign oLine_Start  = run && (hc_q == '0);
  assign oVGA_BLANK   = blk_q[FETCH_LEAD-1];
  assign oVGA_R       = oVGA_BLANK ? r_q : '0;
  assign oVGA_G       = oVGA_BLANK ? g_q : '0;
  assign oVGA_B       = oVGA_BLANK ? b_q : '0;
  assign oVGA_H_SYNC  = hs_q[FETCH_LEAD-1] ? HS_POL : ~HS_POL;
  assign oVGA_V_SYNC  = vs_q[FETCH_LEAD-1] ? VS_POL : ~VS_POL;
  assign oVGA_SYNC    = 1'b0;
  assign oVGA_CLK     = iCLK;

endmodule

// File: tb/tb_vga_timing_engine.sv
// Directed bench for vga_timing_engine: default, lead-3, tiny and
// positive-polarity instances driven from one clock/reset/enable.
module tb_vga_timing_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       en    = 1'b1;
  logic [7:0] red_c = 8'hA5;
  logic [7:0] grn_c = 8'h3C;
  logic [7:0] blu_c = 8'h5A;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // dut0: default mode, lead 2
  logic       req0, fs0, ls0, hs0, vs0, bl0, sy0, ck0;
  logic [9:0] x0, y0;
  logic [7:0] r0, g0, b0;
  vga_timing_engine dut0 (
    .iCLK(clk), .iRST_N(rst_n), .iEnable(en),
    .iRed(red_c), .iGreen(grn_c), .iBlue(blu_c),
    .oReq(req0), .oReq_X(x0), .oReq_Y(y0),
    .oFrame_Start(fs0), .oLine_Start(ls0),
    .oVGA_R(r0), .oVGA_G(g0), .oVGA_B(b0),
    .oVGA_H_SYNC(hs0), .oVGA_V_SYNC(vs0), .oVGA_BLANK(bl0),
    .oVGA_SYNC(sy0), .oVGA_CLK(ck0));

  // dut1: default mode, lead 3, red = x delayed 2 clocks
  logic       req1, fs1, ls1, hs1, vs1, bl1, sy1, ck1;
  logic [9:0] x1, y1;
  logic [7:0] r1, g1, b1;
  logic [7:0] rd1 = 8'h0;
  logic [7:0] rd2 = 8'h0;
  always @(posedge clk) begin
    rd1 <= x1[7:0];
    rd2 <= rd1;
  end
  vga_timing_engine #(.FETCH_LEAD(3)) dut1 (
    .iCLK(clk), .iRST_N(rst_n), .iEnable(en),
    .iRed(rd2), .iGreen(grn_c), .iBlue(blu_c),
    .oReq(req1), .oReq_X(x1), .oReq_Y(y1),
    .oFrame_Start(fs1), .oLine_Start(ls1),
    .oVGA_R(r1), .oVGA_G(g1), .oVGA_B(b1),
    .oVGA_H_SYNC(hs1), .oVGA_V_SYNC(vs1), .oVGA_BLANK(bl1),
    .oVGA_SYNC(sy1), .oVGA_CLK(ck1));

  // dut2: tiny mode 8x6, lead 1
  logic       req2, fs2, ls2, hs2, vs2, bl2, sy2, ck2;
  logic [2:0] x2, y2;
  logic [7:0] r2, g2, b2;
  vga_timing_engine #(
    .H_ACT(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACT(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .FETCH_LEAD(1)) dut2 (
    .iCLK(clk), .iRST_N(rst_n), .iEnable(en),
    .iRed(red_c), .iGreen(grn_c), .iBlue(blu_c),
    .oReq(req2), .oReq_X(x2), .oReq_Y(y2),
    .oFrame_Start(fs2), .oLine_Start(ls2),
    .oVGA_R(r2), .oVGA_G(g2), .oVGA_B(b2),
    .oVGA_H_SYNC(hs2), .oVGA_V_SYNC(vs2), .oVGA_BLANK(bl2),
    .oVGA_SYNC(sy2), .oVGA_CLK(ck2));

  // dut3: 320x128 total, positive syncs, lead 2
  logic       req3, fs3, ls3, hs3, vs3, bl3, sy3, ck3;
  logic [8:0] x3;
  logic [6:0] y3;
  logic [7:0] r3, g3, b3;
  vga_timing_engine #(
    .H_ACT(304), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACT(120), .V_FP(2), .V_SYNC(2), .V_BP(4),
    .HS_POL(1'b1), .VS_POL(1'b1)) dut3 (
    .iCLK(clk), .iRST_N(rst_n), .iEnable(en),
    .iRed(red_c), .iGreen(grn_c), .iBlue(blu_c),
    .oReq(req3), .oReq_X(x3), .oReq_Y(y3),
    .oFrame_Start(fs3), .oLine_Start(ls3),
    .oVGA_R(r3), .oVGA_G(g3), .oVGA_B(b3),
    .oVGA_H_SYNC(hs3), .oVGA_V_SYNC(vs3), .oVGA_BLANK(bl3),
    .oVGA_SYNC(sy3), .oVGA_CLK(ck3));

  int cyc = 0;
  bit p1  = 1'b0;
  bit m3  = 1'b0;

  int brise0 = -1, hfall0 = -1;
  int hs_off0 = -1, hs_per0 = -1, hs_low0 = -1;
  int lcnt0 = -1, lreq0 = -1;
  int rfirst1 = -1, rlast1 = -1, rafter1 = -1;
  int rinc1 = 0, rerr1 = 0;
  int lfs2 = -1, fper2 = -1, fcnt2 = -1, freq2 = -1;
  int xmax2 = 0, ymax2 = 0;
  int hf2 = -1, hlow2 = -1, vf2 = -1, vlow2 = -1, vper2 = -1;
  int hr3 = -1, hhigh3 = -1, vr3 = -1, vhigh3 = -1;
  logic pb0 = 1'b0, phs0 = 1'b1, pb1 = 1'b0;
  logic phs2 = 1'b1, pvs2 = 1'b1, phs3 = 1'b0, pvs3 = 1'b0;
  logic [7:0] pr1 = 8'h0;

  initial forever begin
    @(posedge clk);
    #3;
    cyc++;
    if (p1) begin
      if (bl0 && !pb0) brise0 = cyc;
      if (!hs0 && phs0) begin
        if (hs_off0 < 0 && brise0 >= 0) hs_off0 = cyc - brise0;
        if (hs_per0 < 0 && hfall0 >= 0) hs_per0 = cyc - hfall0;
        hfall0 = cyc;
      end
      if (hs0 && !phs0 && hs_low0 < 0 && hfall0 >= 0)
        hs_low0 = cyc - hfall0;
      if (ls0) begin
        if (lcnt0 >= 0 && lreq0 < 0) lreq0 = lcnt0;
        lcnt0 = 0;
      end
      if (req0 && lcnt0 >= 0) lcnt0++;
      if (bl1 && !pb1 && rfirst1 < 0) rfirst1 = int'(r1);
      if (bl1 && pb1) begin
        rinc1++;
        if (r1 != 8'(pr1 + 8'd1)) rerr1++;
      end
      if (!bl1 && pb1 && rlast1 < 0) begin
        rlast1  = int'(pr1);
        rafter1 = int'(r1);
      end
      if (fs2) begin
        if (lfs2 >= 0 && fper2 < 0) fper2 = cyc - lfs2;
        if (fcnt2 >= 0 && freq2 < 0) freq2 = fcnt2;
        lfs2  = cyc;
        fcnt2 = 0;
      end
      if (req2 && fcnt2 >= 0) fcnt2++;
      if (req2 && int'(x2) > xmax2) xmax2 = int'(x2);
      if (req2 && int'(y2) > ymax2) ymax2 = int'(y2);
      if (!hs2 && phs2) hf2 = cyc;
      if (hs2 && !phs2 && hf2 >= 0 && hlow2 < 0) hlow2 = cyc - hf2;
      if (!vs2 && pvs2) begin
        if (vf2 >= 0 && vper2 < 0) vper2 = cyc - vf2;
        vf2 = cyc;
      end
      if (vs2 && !pvs2 && vf2 >= 0 && vlow2 < 0) vlow2 = cyc - vf2;
    end
    if (m3) begin
      if (hs3 && !phs3) hr3 = cyc;
      if (!hs3 && phs3 && hr3 >= 0 && hhigh3 < 0) hhigh3 = cyc - hr3;
      if (vs3 && !pvs3) vr3 = cyc;
      if (!vs3 && pvs3 && vr3 >= 0 && vhigh3 < 0) vhigh3 = cyc - vr3;
    end
    pb0 = bl0; phs0 = hs0; pb1 = bl1; pr1 = r1;
    phs2 = hs2; pvs2 = vs2; phs3 = hs3; pvs3 = vs3;
  end

  initial begin
    int found, nreq, nbl, nxy;
    found = 0; nreq = 0; nbl = 0; nxy = 0;
    repeat (5) @(negedge clk);
    #1;
    chk("rst_hs", hs0, 1);
    chk("rst_vs", vs0, 1);
    chk("rst_blank", bl0, 0);
    chk("rst_rgb", {r0, g0, b0}, 0);
    chk("rst_req", req0, 0);
    chk("rst_hs_pos", hs3, 0);
    chk("rst_vs_pos", vs3, 0);

    rst_n = 1'b1;
    p1    = 1'b1;
    m3    = 1'b1;
    #1;
    chk("first_fs", fs0, 1);
    chk("first_xy", {x0, y0}, 0);
    chk("first_req", req0, 1);
    chk("first_blank", bl0, 0);
    repeat (10) @(negedge clk);
    #1;
    chk("vis_blank", bl0, 1);
    chk("vis_rgb", {r0, g0, b0}, 24'hA53C5A);
    repeat (2490) @(negedge clk);
    p1 = 1'b0;
    chk("hs_offset", hs_off0, 656);
    chk("hs_period", hs_per0, 800);
    chk("hs_low", hs_low0, 96);
    chk("line_req", lreq0, 640);
    chk("r_first", rfirst1, 0);
    chk("r_last", rlast1, 127);
    chk("r_after", rafter1, 0);
    chk("r_step_err", rerr1, 0);
    chk("r_steps", rinc1 >= 1917, 1);
    chk("tiny_fs_per", fper2, 48);
    chk("tiny_req", freq2, 12);
    chk("tiny_xmax", xmax2, 3);
    chk("tiny_ymax", ymax2, 2);
    chk("tiny_hs_low", hlow2, 2);
    chk("tiny_vs_low", vlow2, 8);
    chk("tiny_vs_per", vper2, 48);
    chk("pos_hs_high", hhigh3, 8);

    for (int i = 0; i < 40000; i++) begin
      @(negedge clk);
      if (x3 == 9'd300 && y3 == 7'd100) begin
        found = 1;
        break;
      end
    end
    chk("find_300_100", found, 1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_x", x3, 0);
    chk("mid_rst_y", y3, 0);
    chk("mid_rst_blank", bl3, 0);
    chk("mid_rst_hs", hs3, 0);
    rst_n = 1'b1;

    repeat (5) @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (req0 || req1 || req2 || req3) nreq++;
      if (i >= 3 && (bl0 || bl1 || bl2 || bl3)) nbl++;
      if (x3 != 9'd0 || y3 != 7'd0) nxy++;
    end
    chk("dis_req", nreq, 0);
    chk("dis_blank", nbl, 0);
    chk("dis_xy", nxy, 0);
    chk("dis_sync", {hs0, vs0, hs3, vs3}, 4'b1100);
    en = 1'b1;
    #1;
    chk("en_fs", fs3, 1);
    chk("en_req", req3, 1);
    chk("en_xy", {x3, y3}, 0);
    chk("en_fs_dflt", fs0, 1);

    for (int i = 0; i < 45000; i++) begin
      @(negedge clk);
      if (vhigh3 >= 0) break;
    end
    chk("pos_vs_high", vhigh3, 640);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
